// File: rtl/ram_bank_router_pkg.sv
// Shared types and helpers for the RAM bank router.
//   state_e  : router FSM states
//   bank_w() : bank index width for a given bank count, never below 1
//   CNT_W    : width of the read-latency counter (read latency is 1..7)
package ram_bank_router_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    localparam int unsigned CNT_W = 3;

    function automatic int unsigned bank_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_bank_router_if.sv
// Request/response handshake between the memory-access controller and the router.
//   req_valid/req_ready : request handshake (ready only while the router is idle)
//   req_we/bank/addr/wdata : request payload; req_bank is one bit wider than needed so
//                         out-of-range indices can always be expressed
//   rsp_valid/rsp_ready : response handshake, response held until taken
//   rsp_err/rsp_rdata   : response payload
// Modports: master = controller side, slave = router side.
interface ram_bank_router_if #(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16
);
    import ram_bank_router_pkg::*;

    localparam int unsigned BANK_W = bank_w(NUM_BANKS);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BANK_W:0]   req_bank;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/ram_bank_router_decoder.sv
// Combinational bank index decoder.
//   idx_i      : bank index (may exceed NUM_BANKS-1)
//   onehot_o   : one-hot enable for the addressed bank, all zero when out of range
//   in_range_o : index addresses an existing bank
module onehot_bank_decoder #(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [IDX_W-1:0]     idx_i,
    output logic [NUM_BANKS-1:0] onehot_o,
    output logic                 in_range_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            onehot_o[i] = (idx_i == IDX_W'(i));
        end
        in_range_o = |onehot_o;
    end

endmodule

// File: rtl/ram_bank_router.sv
// Routes a single request stream to one of NUM_BANKS synchronous RAM banks.
//   clk, rst    : clock and synchronous active-high reset
//   bus         : controller-facing request/response handshake (slave side)
//   bank_en     : registered one-hot bank enable, asserted for one cycle per access
//   bank_we     : write enable, broadcast
//   bank_addr   : word address, broadcast
//   bank_wdata  : write data, broadcast
//   bank_rdata  : flattened read data, bank i at [i*DATA_W +: DATA_W]
// Out-of-range bank indices get an error response without touching any bank. Reads wait
// RD_LAT cycles after the enable cycle before sampling the addressed bank's data.
module ram_bank_router
    import ram_bank_router_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    ram_bank_router_if.slave            bus,
    output logic [NUM_BANKS-1:0]        bank_en,
    output logic                        bank_we,
    output logic [ADDR_W-1:0]           bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata
);

    localparam int unsigned BANK_W = bank_w(NUM_BANKS);
    localparam int unsigned IDX_W  = BANK_W + 1;
    // WAIT lasts RD_LAT cycles, ending on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(RD_LAT - 1);

    state_e               state_q;
    logic [IDX_W-1:0]     bank_q;
    logic                 we_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 req_ready_q;
    logic [NUM_BANKS-1:0] bank_en_q;
    logic                 bank_we_q;
    logic [ADDR_W-1:0]    bank_addr_q;
    logic [DATA_W-1:0]    bank_wdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    logic [NUM_BANKS-1:0] dec_onehot;
    logic                 dec_in_range;
    logic [DATA_W-1:0]    rd_slice;

    onehot_bank_decoder #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (IDX_W)
    ) u_decoder (
        .idx_i      (bus.req_bank),
        .onehot_o   (dec_onehot),
        .in_range_o (dec_in_range)
    );

    // Read data of the latched bank; bank_q is always in range when this is sampled.
    always_comb begin
        rd_slice = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (bank_q == IDX_W'(i)) begin
                rd_slice = bank_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bank_q       <= '0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            bank_en_q    <= '0;
            bank_we_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        bank_q      <= bus.req_bank;
                        we_q        <= bus.req_we;
                        if (dec_in_range) begin
                            state_q      <= StAccess;
                            bank_en_q    <= dec_onehot;
                            bank_we_q    <= bus.req_we;
                            bank_addr_q  <= bus.req_addr;
                            bank_wdata_q <= bus.req_wdata;
                        end else begin
                            // Illegal index: answer straight away, no bank touched.
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                StAccess: begin
                    bank_en_q    <= '0;
                    bank_we_q    <= 1'b0;
                    bank_addr_q  <= '0;
                    bank_wdata_q <= '0;
                    if (we_q) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= CntLoad;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= rd_slice;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bank_en       = bank_en_q;
    assign bank_we       = bank_we_q;
    assign bank_addr     = bank_addr_q;
    assign bank_wdata    = bank_wdata_q;

endmodule
